usb_rx_control: RTL

- Receive control unit for the USB full-speed receiver. Sequences the bit timer and byte counter via `rcving`.
- Checks the SYNC and PID bytes, and issues FIFO writes for payload bytes.
- Validates the EOP position, then reports packet completion or error to the protocol layer.
- Sits between the edge/EOP detectors, the bit timer, the shift register and the RX FIFO.

---
 rtl/usb_rx_control.sv | 93 +++++++++
 1 files changed

// File: rtl/usb_rx_control.sv
// Receive control FSM for the USB full-speed receiver: checks SYNC/PID,
// strobes payload bytes into the RX FIFO and qualifies the EOP.
module usb_rx_control #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_BITS  = 7
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                d_edge,
  input  logic                eop,
  input  logic                shift_enable,
  input  logic                byte_received,
  input  logic [7:0]          rcv_data,
  input  logic                fifo_full,
  output logic                rcving,
  output logic                w_enable,
  output logic                r_error,
  output logic [3:0]          pid,
  output logic                packet_done,
  output logic [CNT_BITS-1:0] byte_count
);

  typedef enum logic [3:0] {
    IDLE, SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK,
    DATA_WAIT, STORE, EOP2, DONE, ERR, EOP_IDLE
  } state_t;

  state_t state, state_d;
  logic   byte_received_q;
  logic   byte_rise, se0_bit, pid_ok, store_ok;

  assign byte_rise = byte_received & ~byte_received_q;
  assign se0_bit   = shift_enable & eop;
  assign pid_ok    = (rcv_data[7:4] == ~rcv_data[3:0]);
  assign store_ok  = ~fifo_full && (byte_count != CNT_BITS'(MAX_BYTES));

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (d_edge) state_d = SYNC_WAIT;
      SYNC_WAIT: if (byte_rise) state_d = SYNC_CHK;
                 else if (se0_bit) state_d = ERR;
      SYNC_CHK:  state_d = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR;
      PID_WAIT:  if (byte_rise) state_d = PID_CHK;
                 else if (se0_bit) state_d = ERR;
      PID_CHK:   state_d = pid_ok ? DATA_WAIT : ERR;
      // A byte completing in the same cycle as SE0 takes priority; EOP is re-checked later.
      DATA_WAIT: if (byte_rise) state_d = STORE;
                 else if (se0_bit) state_d = byte_received ? EOP2 : ERR;
      STORE:     state_d = store_ok ? DATA_WAIT : ERR;
      EOP2:      if (shift_enable) state_d = eop ? DONE : ERR;
      DONE,
      ERR:       state_d = EOP_IDLE;
      EOP_IDLE:  if (d_edge && !eop) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with it.
  // NOTE: all state and output flops use non-blocking assignments to avoid update-order races.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state           <= IDLE;
      byte_received_q <= 1'b0;
      rcving          <= 1'b0;
      w_enable        <= 1'b0;
      r_error         <= 1'b0;
      pid             <= 4'h0;
      packet_done     <= 1'b0;
      byte_count      <= '0;
    end else begin
      state           <= state_d;
      byte_received_q <= byte_received;
      rcving          <= state_d inside {SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK,
                                         DATA_WAIT, STORE, EOP2};
      w_enable        <= (state == STORE) && (state_d == DATA_WAIT);
      packet_done     <= (state_d == DONE);

      if (state == IDLE && state_d == SYNC_WAIT) r_error <= 1'b0;
      else if (state_d == ERR)                   r_error <= 1'b1;

      if (state == PID_CHK && state_d == DATA_WAIT) begin
        pid        <= rcv_data[3:0];
        byte_count <= '0;
      end else if (state == STORE && state_d == DATA_WAIT) begin
        byte_count <= byte_count + 1'b1;
      end
    end
  end

endmodule
